// File: rtl/alu_pkg.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : alu_pkg                                                     |
// | Desc   : Shared widths and data type for the vcpu1 ALU datapath.     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
package alu_pkg;
  localparam int ALU_DATA_W  = 32;
  localparam int CLA_GROUP_W = 4;

  typedef logic [ALU_DATA_W-1:0] alu_word_t;
endpackage
`default_nettype wire

// File: rtl/cla4.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : cla4                                                        |
// | Desc   : 4-bit carry-lookahead group with group propagate/generate.  |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module cla4
  import alu_pkg::*;
(
  input  logic [CLA_GROUP_W-1:0] a,
  input  logic [CLA_GROUP_W-1:0] b,
  input  logic                   cin,
  output logic [CLA_GROUP_W-1:0] sum,
  output logic                   pg,
  output logic                   gg
);

  logic [CLA_GROUP_W-1:0] w_p;
  logic [CLA_GROUP_W-1:0] w_g;
  logic [CLA_GROUP_W-1:0] w_c;

  assign w_p = a ^ b;
  assign w_g = a & b;

  // Every internal carry is a flat sum of products of cin and the bit p/g terms.
  assign w_c[0] = cin;
  assign w_c[1] = w_g[0] | (w_p[0] & cin);
  assign w_c[2] = w_g[1] | (w_p[1] & w_g[0]) | (w_p[1] & w_p[0] & cin);
  assign w_c[3] = w_g[2] | (w_p[2] & w_g[1]) | (w_p[2] & w_p[1] & w_g[0])
                | (w_p[2] & w_p[1] & w_p[0] & cin);

  assign sum = w_p ^ w_c;
  assign pg  = &w_p;
  assign gg  = w_g[3] | (w_p[3] & w_g[2]) | (w_p[3] & w_p[2] & w_g[1])
             | (w_p[3] & w_p[2] & w_p[1] & w_g[0]);

endmodule
`default_nettype wire

// File: rtl/adder_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : adder_32                                                    |
// | Desc   : Two-level CLA adder with combinational and registered       |
// |          sum/overflow. ADDER_CARRY_OUT_EN exposes the final carry.   |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module adder_32
  import alu_pkg::*;
#(
  parameter int WIDTH = ALU_DATA_W
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  input  logic             in_valid,
  output logic [WIDTH-1:0] s,
  output logic             overflow,
  output logic [WIDTH-1:0] s_q,
  output logic             overflow_q,
`ifdef ADDER_CARRY_OUT_EN
  output logic             carry_out,
  output logic             carry_out_q,
`endif
  output logic             out_valid
);

  localparam int c_groups = WIDTH / CLA_GROUP_W;

  logic [c_groups-1:0] w_gp;
  logic [c_groups-1:0] w_gg;
  logic [c_groups:0]   w_gcarry;
  logic                w_term;
  alu_word_t           w_sum;
  logic                w_ovf;

  genvar gi;
  generate
    for (gi = 0; gi < c_groups; gi++) begin : g_cla
      cla4 u_cla4 (
        .a   (a[gi*CLA_GROUP_W +: CLA_GROUP_W]),
        .b   (b[gi*CLA_GROUP_W +: CLA_GROUP_W]),
        .cin (w_gcarry[gi]),
        .sum (w_sum[gi*CLA_GROUP_W +: CLA_GROUP_W]),
        .pg  (w_gp[gi]),
        .gg  (w_gg[gi])
      );
    end
  endgenerate

  // Second lookahead level: each group carry is expanded into its own
  // sum of products so no carry depends on the previous group's carry.
  always_comb begin
    w_gcarry = '0;
    w_term   = 1'b0;
    for (int i = 1; i <= c_groups; i++) begin
      for (int j = 0; j < i; j++) begin
        w_term = w_gg[j];
        for (int k = j + 1; k < i; k++) begin
          w_term = w_term & w_gp[k];
        end
        w_gcarry[i] = w_gcarry[i] | w_term;
      end
    end
  end

  assign w_ovf    = (a[WIDTH-1] == b[WIDTH-1]) && (w_sum[WIDTH-1] != a[WIDTH-1]);
  assign s        = w_sum;
  assign overflow = w_ovf;

  logic [WIDTH-1:0] r_s_q;
  logic             r_overflow_q;
  logic             r_out_valid;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_s_q        <= '0;
      r_overflow_q <= 1'b0;
      r_out_valid  <= 1'b0;
    end else begin
      r_out_valid <= in_valid;
      if (in_valid) begin
        r_s_q        <= w_sum;
        r_overflow_q <= w_ovf;
      end
    end
  end

  assign s_q        = r_s_q;
  assign overflow_q = r_overflow_q;
  assign out_valid  = r_out_valid;

`ifdef ADDER_CARRY_OUT_EN
  logic r_carry_out_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_carry_out_q <= 1'b0;
    end else if (in_valid) begin
      r_carry_out_q <= w_gcarry[c_groups];
    end
  end

  assign carry_out   = w_gcarry[c_groups];
  assign carry_out_q = r_carry_out_q;
`else
  logic w_unused_carry;
  assign w_unused_carry = w_gcarry[c_groups];
`endif

endmodule
`default_nettype wire

// File: tb/tb_adder_32.sv
`default_nettype none
// +----------------------------------------------------------------------+
// | Module : tb_adder_32                                                 |
// | Desc   : Scoreboard bench for adder_32 (directed plan + random).     |
// | Rev    : 1.0                                                         |
// +----------------------------------------------------------------------+
module tb_adder_32;

  logic        clk;
  logic        rst_n;
  logic [31:0] a;
  logic [31:0] b;
  logic        in_valid;
  logic [31:0] s;
  logic        overflow;
  logic [31:0] s_q;
  logic        overflow_q;
  logic        out_valid;
`ifdef ADDER_CARRY_OUT_EN
  logic        carry_out;
  logic        carry_out_q;
`endif

  adder_32 #(.WIDTH(32)) dut (
    .clk        (clk),
    .rst_n      (rst_n),
    .a          (a),
    .b          (b),
    .in_valid   (in_valid),
    .s          (s),
    .overflow   (overflow),
    .s_q        (s_q),
    .overflow_q (overflow_q),
`ifdef ADDER_CARRY_OUT_EN
    .carry_out  (carry_out),
    .carry_out_q(carry_out_q),
`endif
    .out_valid  (out_valid)
  );

  typedef struct {
    logic        v;
    logic [31:0] s;
    logic        ov;
    logic        co;
  } exp_t;

  exp_t        q[$];
  int          tests = 0;
  int          fails = 0;
  logic        mon_en = 1'b0;
  logic [31:0] hold_s = '0;
  logic        hold_ov = 1'b0;
  logic        hold_co = 1'b0;

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Reference: exact integer arithmetic; overflow means the wrapped result
  // differs from the true signed sum.
  function automatic void model(input logic [31:0] ma, input logic [31:0] mb,
                                output logic [31:0] ms, output logic mov,
                                output logic mco);
    logic [32:0] u;
    longint      sa;
    u   = {1'b0, ma} + {1'b0, mb};
    ms  = u[31:0];
    mco = u[32];
    sa  = longint'($signed(ma)) + longint'($signed(mb));
    mov = (sa != longint'($signed(ms)));
  endfunction

  task automatic drive(input logic [31:0] ta, input logic [31:0] tbv, input logic v);
    exp_t        e;
    logic [31:0] es;
    logic        eo;
    logic        ec;
    @(negedge clk);
    a = ta;
    b = tbv;
    in_valid = v;
    model(ta, tbv, es, eo, ec);
    #1;
    tests++;
    if (s !== es || overflow !== eo) begin
      fails++;
      $display("FAIL comb a=%h b=%h: got s=%h ov=%b, want s=%h ov=%b", ta, tbv, s, overflow, es, eo);
    end
`ifdef ADDER_CARRY_OUT_EN
    tests++;
    if (carry_out !== ec) begin
      fails++;
      $display("FAIL carry a=%h b=%h: got %b, want %b", ta, tbv, carry_out, ec);
    end
`endif
    e.v = v; e.s = es; e.ov = eo; e.co = ec;
    q.push_back(e);
  endtask

  task automatic chk_lit(input string name, input logic [31:0] es, input logic eo, input logic ec);
    tests++;
    if (s !== es || overflow !== eo) begin
      fails++;
      $display("FAIL %s: got s=%h ov=%b, want s=%h ov=%b", name, s, overflow, es, eo);
    end
`ifdef ADDER_CARRY_OUT_EN
    tests++;
    if (carry_out !== ec) begin
      fails++;
      $display("FAIL %s carry: got %b, want %b", name, carry_out, ec);
    end
`else
    if (ec === 1'bx) $display("note: undefined carry expectation in %s", name);
`endif
  endtask

  task automatic chk_regs(input string name, input logic [31:0] es, input logic eo, input logic ev);
    tests++;
    if (s_q !== es || overflow_q !== eo || out_valid !== ev) begin
      fails++;
      $display("FAIL %s: got s_q=%h ov_q=%b vld=%b, want s_q=%h ov_q=%b vld=%b",
               name, s_q, overflow_q, out_valid, es, eo, ev);
    end
  endtask

  // Monitor: one expected entry per driven cycle, checked after the edge.
  initial begin
    exp_t e;
    forever begin
      @(posedge clk);
      #1;
      if (mon_en && q.size() > 0) begin
        e = q.pop_front();
        if (e.v) begin
          hold_s  = e.s;
          hold_ov = e.ov;
          hold_co = e.co;
        end
        tests++;
        if (out_valid !== e.v || s_q !== hold_s || overflow_q !== hold_ov) begin
          fails++;
          $display("FAIL reg: got s_q=%h ov_q=%b vld=%b, want s_q=%h ov_q=%b vld=%b",
                   s_q, overflow_q, out_valid, hold_s, hold_ov, e.v);
        end
`ifdef ADDER_CARRY_OUT_EN
        tests++;
        if (carry_out_q !== hold_co) begin
          fails++;
          $display("FAIL reg carry: got %b, want %b", carry_out_q, hold_co);
        end
`endif
      end
    end
  end

  initial begin
    logic [31:0] ta;
    logic [31:0] tbv;
    rst_n = 1'b1; a = '0; b = '0; in_valid = 1'b0;
    #2 rst_n = 1'b0;
    #1 chk_regs("reset_async", 32'h0, 1'b0, 1'b0);
    @(posedge clk); @(posedge clk);
    @(negedge clk) rst_n = 1'b1;
    mon_en = 1'b1;

    drive(32'h0, 32'h0, 1'b1);
    chk_lit("zero", 32'h0, 1'b0, 1'b0);

    ta = 32'h123; tbv = 32'h789;
    drive(ta, tbv, 1'b1);
    chk_lit("inc_start", 32'h8AC, 1'b0, 1'b0);
    for (int i = 0; i < 10; i++) begin
      ta += 100; tbv += 100;
      drive(ta, tbv, 1'b1);
    end
    chk_lit("inc_final", 32'h107C, 1'b0, 1'b0);

    ta = 32'hFFFF0000; tbv = 32'h0000F996;
    drive(ta, tbv, 1'b1);
    for (int i = 1; i <= 5; i++) begin
      ta += 32'h100; tbv += 32'h100;
      drive(ta, tbv, 1'b1);
      if (i == 3) chk_lit("wrap_step3", 32'hFFFFFF96, 1'b0, 1'b0);
      if (i == 4) chk_lit("wrap_step4", 32'h196, 1'b0, 1'b1);
    end

    drive(32'h7FFFFFFF, 32'h1, 1'b1);
    chk_lit("ovf_pos", 32'h80000000, 1'b1, 1'b0);
    drive(32'h80000000, 32'h80000000, 1'b1);
    chk_lit("ovf_neg", 32'h0, 1'b1, 1'b1);
    drive(32'hFFFFFFFF, 32'h1, 1'b1);
    chk_lit("minus1_plus1", 32'h0, 1'b0, 1'b1);

    // Registered path and mid-operation reset
    drive(32'd5, 32'd7, 1'b1);
    drive(32'd0, 32'd0, 1'b0);
    @(posedge clk);
    #2 chk_regs("hold_12", 32'd12, 1'b0, 1'b0);
    mon_en = 1'b0;
    q.delete();
    drive(32'd9, 32'd9, 1'b1);
    @(posedge clk);
    #2 rst_n = 1'b0;
    #1 chk_regs("reset_mid", 32'h0, 1'b0, 1'b0);
    hold_s = '0; hold_ov = 1'b0; hold_co = 1'b0;
    q.delete();
    in_valid = 1'b0;
    #1 rst_n = 1'b1;
    mon_en = 1'b1;

    for (int i = 0; i < 10000; i++) begin
      drive($urandom, $urandom, 1'($urandom_range(0, 3) != 0));
    end

    drive(32'h0, 32'h0, 1'b0);
    @(posedge clk); @(posedge clk);
    #2;
    tests++;
    if (q.size() != 0) begin
      fails++;
      $display("FAIL drain: got %0d entries left, want 0", q.size());
    end

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/adder_32.md
Name: adder_32

Overview:
- 32-bit two's-complement adder for the vcpu1 ALU.
- Produces a combinational sum and signed-overflow flag with zero latency, used by the ALU datapath.
- Also provides a one-cycle registered copy of both results, with a valid strobe, for pipeline-stage consumers.
- Internally a carry-lookahead structure built from 4-bit CLA groups.

Parameters:
- WIDTH, 32, operand/sum width; the block is verified at 32 only, and other values are unsupported.

Ports:
- clk  input  1  single clock; all registers update on its rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- a  input  32  operand A.
- b  input  32  operand B.
- in_valid  input  1  qualifies a/b for the registered path.
- s  output  32  combinational sum a+b mod 2^32.
- overflow  output  1  combinational signed overflow.
- s_q  output  32  registered s.
- overflow_q  output  1  registered overflow.
- out_valid  output  1  registered in_valid.

Behaviour:
- s = (a + b) mod 2^32 with no carry-in; purely combinational.
- s and overflow settle within the same evaluation; no clock is required for them.
- overflow = (a[31] == b[31]) && (s[31] != a[31]).
- overflow is never set when the operand signs differ.
- The unsigned carry out of bit 31 is discarded from s; it is exposed only under the optional feature.
- Adder structure: eight 4-bit CLA groups, each producing group propagate/generate.
- Group-level carries come from a second lookahead level; ripple-carry across groups is not allowed.
- Result must be bit-exact with a behavioural a+b for all inputs.
- Registered path, on each rising clk edge:
  - out_valid <= in_valid.
  - When in_valid = 1: s_q <= s and overflow_q <= overflow.
  - When in_valid = 0: s_q and overflow_q hold their previous values.
- Latency: 0 cycles combinational; 1 cycle registered.
- Reset: when rst_n goes low, s_q = 0, overflow_q = 0 and out_valid = 0 immediately, independent of clk.
  - Reset mid-operation drops any in-flight result.
  - The combinational outputs s and overflow are unaffected by reset.
  - The first capture after rst_n rises occurs on the first rising clk edge with in_valid = 1.
- X on inputs may propagate to outputs; there is no special handling.

Optional Feature:
- Macro: ADDER_CARRY_OUT_EN.
- Defined:
  - Adds output port carry_out (1 bit): the unsigned carry out of bit 31, combinational.
  - Adds carry_out_q, registered under the same in_valid/reset rules (reset value 0).
- Not defined: neither port exists, and the final carry is left unused.
- s and overflow are identical in both builds.

Decomposition:
- Shared package alu_pkg holds:
  - constant ALU_DATA_W = 32;
  - constant CLA_GROUP_W = 4;
  - a 32-bit data word typedef.
- One sub-module, cla4:
  - Inputs: 4-bit a, b, cin.
  - Outputs: 4-bit sum, group propagate, group generate.
  - adder_32 instantiates it eight times, plus the second-level lookahead logic.

Test Plan:
- a=0, b=0 -> s=0x00000000, overflow=0 (carry_out=0).
- a=0x123, b=0x789 -> s=0x000008AC. Then add 100 (decimal) to both operands ten times, checking each step against a+b. Final step a=0x50B, b=0xB71 -> s=0x107C, overflow=0.
- Wrap: start a=0xFFFF0000, b=0xF996 and add 0x100 to both five times, checking every step.
  - Step 3: s=0xFFFFFF96.
  - Step 4: a=0xFFFF0400, b=0xFD96 -> s=0x00000196, overflow=0, carry_out=1.
- Signed overflow:
  - 0x7FFFFFFF+0x00000001 -> s=0x80000000, overflow=1.
  - 0x80000000+0x80000000 -> s=0, overflow=1, carry_out=1.
  - 0xFFFFFFFF+0x00000001 -> s=0, overflow=0.
- Registered path:
  - With in_valid=1 and a=5, b=7 at edge N: s_q=12 and out_valid=1 after edge N.
  - With in_valid=0 at edge N+1: s_q holds 12 and out_valid=0.
  - Asserting rst_n=0 between edges clears s_q, overflow_q and out_valid immediately.
- Random: 10k random a/b pairs, s and overflow compared with a behavioural model each step, zero mismatches required.
